// File: rtl/serial_frame_tx.sv
// serial_frame_tx: sends a parallel payload word as one serial frame on the
// 1101-sync serial link. Each frame is SYNC_WORD MSB-first, then the payload
// MSB-first, then GAP_LEN zero guard bits.
// Optional macro SERIAL_TX_PARITY_EN appends one even-parity bit after the
// payload. With it defined, done moves from the last data bit to that bit.
module serial_frame_tx #(
   parameter int unsigned        SYNC_W    = 4,
   parameter logic [SYNC_W-1:0]  SYNC_WORD = 4'b1101,
   parameter int unsigned        DATA_W    = 8,
   parameter int unsigned        GAP_LEN   = 2
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              dat_out,
   output logic              sync_out,
   output logic              frame_active,
   output logic              done
);

   localparam logic [7:0] SYNC_LAST = 8'(SYNC_W - 1);
   localparam logic [7:0] DATA_LAST = 8'(DATA_W - 1);
   localparam logic [7:0] GAP_LAST  = 8'(GAP_LEN - 1);

`ifdef SERIAL_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, SYNC, DATA, PAR, GAP} state_t;
`else
   typedef enum logic [2:0] {IDLE, SYNC, DATA, GAP} state_t;
`endif

   state_t              state, state_nxt;
   logic [7:0]          cnt, cnt_nxt;
   logic [DATA_W-1:0]   data_sr, data_sr_nxt;
   logic [SYNC_W-1:0]   sync_sr, sync_sr_nxt;
   logic                dat_nxt, sync_nxt, active_nxt, done_nxt;
`ifdef SERIAL_TX_PARITY_EN
   logic                par, par_nxt;
`endif

   // Ready only while idle and out of reset.
   assign din_ready = (state == IDLE) && rst;

   // State, counter, shift registers and registered outputs.
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         cnt          <= '0;
         data_sr      <= '0;
         sync_sr      <= '0;
         dat_out      <= 1'b0;
         sync_out     <= 1'b0;
         frame_active <= 1'b0;
         done         <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         par          <= 1'b0;
`endif
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         data_sr      <= data_sr_nxt;
         sync_sr      <= sync_sr_nxt;
         dat_out      <= dat_nxt;
         sync_out     <= sync_nxt;
         frame_active <= active_nxt;
         done         <= done_nxt;
`ifdef SERIAL_TX_PARITY_EN
         par          <= par_nxt;
`endif
      end
   end

   // Next state, then the outputs of the cycle being entered. Outputs are
   // derived from the next state so dat_out can stay registered while the
   // first sync bit still appears one cycle after the accept edge.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      data_sr_nxt = data_sr;
      sync_sr_nxt = sync_sr;
      dat_nxt     = 1'b0;
      sync_nxt    = 1'b0;
      active_nxt  = 1'b0;
      done_nxt    = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_nxt     = par;
`endif

      case (state)
         IDLE: begin
            if (din_valid) begin
               state_nxt   = SYNC;
               cnt_nxt     = '0;
               data_sr_nxt = din;
               sync_sr_nxt = SYNC_WORD;
`ifdef SERIAL_TX_PARITY_EN
               par_nxt     = ^din;
`endif
            end
         end
         SYNC: begin
            if (cnt == SYNC_LAST) begin
               state_nxt = DATA;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         DATA: begin
            if (cnt == DATA_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
               state_nxt = PAR;
`else
               state_nxt = (GAP_LEN == 0) ? IDLE : GAP;
`endif
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         PAR: begin
            state_nxt = (GAP_LEN == 0) ? IDLE : GAP;
            cnt_nxt   = '0;
         end
`endif
         GAP: begin
            if (cnt == GAP_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase

      // Shift registers emit their MSB and move up as each bit is entered.
      case (state_nxt)
         SYNC: begin
            dat_nxt     = sync_sr_nxt[SYNC_W-1];
            sync_sr_nxt = sync_sr_nxt << 1;
            sync_nxt    = 1'b1;
            active_nxt  = 1'b1;
         end
         DATA: begin
            dat_nxt     = data_sr_nxt[DATA_W-1];
            data_sr_nxt = data_sr_nxt << 1;
            active_nxt  = 1'b1;
`ifndef SERIAL_TX_PARITY_EN
            done_nxt    = (cnt_nxt == DATA_LAST);
`endif
         end
`ifdef SERIAL_TX_PARITY_EN
         PAR: begin
            dat_nxt    = par_nxt;
            active_nxt = 1'b1;
            done_nxt   = 1'b1;
         end
`endif
         default: begin
            dat_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: default instance plus a short
// DATA_W=4 / GAP_LEN=0 instance. Expectations follow SERIAL_TX_PARITY_EN.
module tb_serial_frame_tx;

`ifdef SERIAL_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int L  = 4 + 8 + P + 2;  // default frame length without IDLE
   localparam int LS = 4 + 4 + P;      // short frame length, no gap

   logic       sys_clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] din = '0;
   logic       din_valid = 1'b0;
   logic       din_ready, dat_out, sync_out, frame_active, done;
   logic [3:0] din4 = '0;
   logic       valid4 = 1'b0;
   logic       ready4, dat4, sync4, active4, done4;

   int checks = 0;
   int errors = 0;

   always #5 sys_clk = ~sys_clk;

   serial_frame_tx u_dut (
      .sys_clk(sys_clk), .rst(rst), .din(din), .din_valid(din_valid),
      .din_ready(din_ready), .dat_out(dat_out), .sync_out(sync_out),
      .frame_active(frame_active), .done(done)
   );

   serial_frame_tx #(.SYNC_W(4), .SYNC_WORD(4'b1101), .DATA_W(4), .GAP_LEN(0)) u_short (
      .sys_clk(sys_clk), .rst(rst), .din(din4), .din_valid(valid4),
      .din_ready(ready4), .dat_out(dat4), .sync_out(sync4),
      .frame_active(active4), .done(done4)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Expected dat_out of the default instance at cycle c after the accept.
   function automatic logic exp_bit(input logic [7:0] d, input int c);
      logic [3:0] sw;
      sw = 4'b1101;
      if (c >= 1 && c <= 4) return sw[4 - c];
      if (c >= 5 && c <= 12) return d[12 - c];
      if (c == 13 && P == 1) return ^d;
      return 1'b0;
   endfunction

   // Offer d from an IDLE negedge, check every cycle through the next IDLE.
   task automatic frame(input logic [7:0] d, input bit hold);
      din = d;
      din_valid = 1'b1;
      chk("ready_before", din_ready, 1'b1);
      for (int c = 1; c <= L + 1; c++) begin
         @(negedge sys_clk);
         chk("dat", dat_out, exp_bit(d, c));
         chk("sync", sync_out, c <= 4);
         chk("active", frame_active, c <= 12 + P);
         chk("done", done, c == 12 + P);
         chk("ready", din_ready, c == L + 1);
         if (c == 1) begin
            din = ~d;
            din_valid = hold;
         end
      end
   endtask

   initial begin
      // Reset state
      #1;
      chk("rst_ready", din_ready, 1'b0);
      chk("rst_dat", dat_out, 1'b0);
      chk("rst_sync", sync_out, 1'b0);
      chk("rst_active", frame_active, 1'b0);
      chk("rst_done", done, 1'b0);
      @(negedge sys_clk);
      @(negedge sys_clk);
      rst = 1'b1;
      @(negedge sys_clk);
      chk("idle_ready", din_ready, 1'b1);

      // Single pulsed frame A5
      frame(8'hA5, 1'b0);

      // Back-to-back FF then 00 with valid held
      frame(8'hFF, 1'b1);
      frame(8'h00, 1'b0);

      // Extra payload containing the sync pattern, sent unmodified
      frame(8'hD7, 1'b0);

      // Idle for 20 cycles
      for (int i = 0; i < 20; i++) begin
         @(negedge sys_clk);
         chk("idle_dat", dat_out, 1'b0);
         chk("idle_rdy", din_ready, 1'b1);
         chk("idle_sync", sync_out, 1'b0);
         chk("idle_act", frame_active, 1'b0);
         chk("idle_done", done, 1'b0);
      end

      // Reset at data bit 3
      din = 8'h3C;
      din_valid = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge sys_clk);
         chk("pre_rst_dat", dat_out, exp_bit(8'h3C, c));
         if (c == 1) din_valid = 1'b0;
      end
      rst = 1'b0;
      #1;
      chk("mid_rst_dat", dat_out, 1'b0);
      chk("mid_rst_sync", sync_out, 1'b0);
      chk("mid_rst_act", frame_active, 1'b0);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_rdy", din_ready, 1'b0);
      @(negedge sys_clk);
      @(negedge sys_clk);
      chk("held_rst_dat", dat_out, 1'b0);
      rst = 1'b1;
      #1;
      chk("post_rst_rdy", din_ready, 1'b1);
      @(negedge sys_clk);
      chk("post_rst_dat", dat_out, 1'b0);
      chk("post_rst_rdy2", din_ready, 1'b1);
      frame(8'h96, 1'b0);

      // Parity payload with odd count of ones
      frame(8'h07, 1'b0);

      // Short instance: GAP_LEN=0, DATA_W=4, valid held
      din4 = 4'hD;
      valid4 = 1'b1;
      chk("s_ready_before", ready4, 1'b1);
      for (int c = 1; c <= LS + 2; c++) begin
         logic [7:0] sb;
         logic e;
         sb = 8'b1101_1101;
         if (c <= 8) e = sb[8 - c];
         else if (c == 9 && P == 1) e = 1'b1;
         else if (c == LS + 1) e = 1'b0;
         else e = 1'b1;
         @(negedge sys_clk);
         chk("s_dat", dat4, e);
         chk("s_sync", sync4, (c <= 4) || (c == LS + 2));
         chk("s_active", active4, (c <= 8 + P) || (c == LS + 2));
         chk("s_done", done4, c == 8 + P);
         chk("s_ready", ready4, c == LS + 1);
         if (c == 1) din4 = 4'h0;
      end
      valid4 = 1'b0;
      for (int i = 0; i < LS; i++) @(negedge sys_clk);
      chk("s_ready_end", ready4, 1'b1);
      chk("s_dat_end", dat4, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Serial frame transmitter for the 1101-sync serial link. Accepts a parallel payload word over a valid/ready handshake and emits it one bit per sys_clk on dat_out. Each frame is a fixed sync word, then the payload MSB-first, then zero-filled guard bits. It is the transmit end of the sync-detect receive path; the guard gap gives the receiver its required spacing between sync hits.

Parameters:
SYNC_W, 4, sync word width in bits (1..8)
SYNC_WORD, 4'b1101, sync pattern, sent MSB-first
DATA_W, 8, payload width in bits (1..32)
GAP_LEN, 2, guard bits (dat_out=0) after each frame (0..255)

Ports:
sys_clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
din  in  DATA_W  payload word
din_valid  in  1  payload present
din_ready  out  1  block can accept payload this cycle
dat_out  out  1  serial bit stream (registered)
sync_out  out  1  high while a sync bit is on dat_out
frame_active  out  1  high while sync/data/parity bits are on dat_out
done  out  1  one-cycle pulse coincident with the last data (or parity) bit

Behaviour:
- Reset (rst=0, async): state=IDLE; dat_out=0, sync_out=0, frame_active=0, done=0; din_ready=0 while rst=0; shift register and counters cleared. Reset mid-frame aborts the frame immediately. No partial resume.
- din_ready = (state==IDLE) and rst=1. It is combinational from state.
- Accept = din_valid & din_ready at a rising edge. din is captured into the shift register. Later changes to din are ignored until the next accept.
- FSM states: IDLE, SYNC, DATA, PAR (only if the optional feature is enabled), GAP.
- IDLE: dat_out=0. On accept, go to SYNC. The first sync bit SYNC_WORD[SYNC_W-1] appears on dat_out in the cycle right after the accept edge (latency 1).
- SYNC: SYNC_W cycles, sending SYNC_WORD MSB->LSB. sync_out=1 and frame_active=1. Then go to DATA.
- DATA: DATA_W cycles, sending din MSB->LSB. frame_active=1. done=1 on the last data bit unless PAR is enabled. Then go to PAR, or to GAP (or to IDLE if GAP_LEN=0).
- GAP: GAP_LEN cycles with dat_out=0 and all flags 0. Then go to IDLE.
- Back-to-back: with din_valid held high, one IDLE cycle (dat_out=0) sits between frames. Frame period = SYNC_W + DATA_W (+1 with parity) + GAP_LEN + 1 cycles.
- Counters: bit counter is 8 bits and wraps only by reload on state change. Counts are compared against parameter-1, so no off-by-one at the last bit.
- din_valid is never dropped: a word offered outside IDLE is not consumed and no data is lost.
- A payload that itself contains the sync pattern is sent unmodified. No bit stuffing.

Optional Feature:
SERIAL_TX_PARITY_EN. When defined, PAR adds one cycle after DATA. dat_out = even parity over the captured payload (XOR of all DATA_W bits). frame_active=1 and done=1 in that cycle. When undefined, there is no PAR state, done coincides with the last data bit, and the frame is one bit shorter.

Test Plan:
1. Defaults, no parity, din=8'hA5 pulsed with din_valid for 1 cycle.
   - dat_out from the next cycle = 1,1,0,1, 1,0,1,0,0,1,0,1, 0,0, then 0.
   - sync_out high for cycles 1-4; frame_active for cycles 1-12; done at cycle 12.
   - din_ready low for cycles 1-14, high again at cycle 15.
2. din_valid held high with din=8'hFF then 8'h00.
   - Frames start 15 cycles apart. Exactly one IDLE 0 sits between the gap and the next sync.
   - Second payload bits are all 0.
3. din_valid=0 for 20 cycles: dat_out=0, din_ready=1, no flags, no done.
4. rst asserted at data bit 3 of a frame.
   - All outputs go to 0 immediately.
   - After release: IDLE, din_ready=1. The next accept starts a fresh sync 1101.
5. SERIAL_TX_PARITY_EN defined, din=8'h07.
   - Bit 13 = 1 (odd count of ones), done at cycle 13, then 2 gap zeros. Period is 16.
6. Parameters GAP_LEN=0, DATA_W=4, din=4'hD.
   - Stream 1101 1101 followed directly by an IDLE 0.
   - The next accept is possible on the cycle after the last data bit.
